// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter that shares one uart_tx byte input
// between NUM_REQ byte-stream requesters; the byte path is combinational.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_pause,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] pick;
  logic          found;
  logic          fire;

  // First valid requester at or after ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign fire = (state == OWN) && req_valid[owner] && out_ready && req_last[owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (!tx_pause && found) begin
          state_nxt = OWN;
          owner_nxt = pick;
        end
      end
      OWN: begin
        if (fire) begin
          state_nxt = IDLE;
          ptr_nxt   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state == OWN) begin
      busy             = 1'b1;
      grant[owner]     = 1'b1;
      out_valid        = req_valid[owner];
      out_data         = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      req_ready[owner] = out_ready;
    end
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Shares the single uart_tx byte stream between NUM_REQ independent byte-stream requesters, e.g. a command responder, a loopback path and debug/status emitters.
- Arbitration is round-robin at packet granularity: once granted, a requester owns the transmitter until it delivers a byte flagged last.
- Sits between the requesters and uart_tx's byte_in_data/valid/ready.
- A pause input lets flow control (synchronised host RTS) stop new packets from starting without cutting a packet in half.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 8, byte width carried on each requester and on the output.

Ports:
- clk  input  1  system clock (100 MHz domain).
- rst  input  1  synchronous, active-high reset.
- req_data  input  NUM_REQ*DATA_WIDTH  packed requester bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_ready  output  NUM_REQ  per-requester byte accepted when valid&ready.
- tx_pause  input  1  when high, no new grant is issued; an in-progress packet completes.
- out_data  output  DATA_WIDTH  byte to uart_tx byte_in_data.
- out_valid  output  1  to uart_tx byte_in_valid.
- out_ready  input  1  from uart_tx byte_in_ready.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  high while a packet owns the transmitter.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: grant=0, busy=0, out_valid=0, req_ready=0, round-robin pointer ptr=0. out_data is don't-care while out_valid=0; it is driven 0 in reset.
- State machine: two states.
  - IDLE: busy=0, grant=0, out_valid=0, req_ready=0.
  - OWN: busy=1, grant=onehot(owner).
- IDLE -> OWN: when tx_pause=0 and any req_valid=1.
  - Owner = first index with req_valid=1, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
  - The grant is registered and visible on the next cycle; no byte is accepted in the arbitration cycle.
  - If tx_pause=1, the block stays in IDLE regardless of requests.
- In OWN, the datapath is purely combinational:
  - out_data = req_data[owner], out_valid = req_valid[owner].
  - req_ready[owner] = out_ready; all other req_ready = 0.
  - This gives zero added latency per byte and full throughput. Back-to-back bytes transfer every cycle uart_tx is ready.
- Packet termination: OWN -> IDLE on the cycle where req_valid[owner] & out_ready & req_last[owner].
  - In that cycle ptr <= (owner+1) mod NUM_REQ.
  - The next packet is granted no earlier than 1 cycle later: exactly one idle bubble cycle between packets.
- Owner deasserting valid mid-packet: the grant is held indefinitely. There is no timeout and other requesters wait. out_valid follows req_valid[owner].
- tx_pause asserted during OWN has no effect until the packet's last byte. It is sampled only in IDLE.
- Single-byte packet (last on the first byte) is legal: OWN lasts exactly as long as that one handshake takes.
- A requester with valid=0 is skipped by the search. If only one requester is active, it is re-granted after each bubble.
- Simultaneous valid on all requesters with ptr=k: grant order is k, k+1, ..., wrapping. Fairness bound: a continuously requesting requester waits at most NUM_REQ-1 packets.
- Reset mid-packet: the next cycle is IDLE with ptr=0 and out_valid=0. The partially sent packet is truncated; the requester sees req_ready=0 and must handle its own flush.
- Invariants:
  - grant is at most one-hot.
  - out_valid implies busy.
  - At most one req_ready is high, and it is high only for the owner.
  - No byte is duplicated or dropped: each out handshake corresponds 1:1 to an owner handshake.

Test Plan:
- Reset, then all req_valid=0 for 20 cycles -> grant=0, busy=0, out_valid=0, req_ready=0 throughout.
- NUM_REQ=4; req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with out_ready=1 -> grant=0001 on cycle 1, bytes appear on cycles 1..3, busy drops cycle 4, ptr=1.
- All 4 requesters hold a 2-byte packet ready simultaneously, out_ready=1 -> packets emitted in order 0,1,2,3; each takes 2 cycles plus 1 bubble; 12 cycles total after the first arbitration cycle.
- req1 mid-packet; assert tx_pause; req2 valid -> req1 finishes its last byte, then the block stays IDLE while paused. Deassert pause -> req2 granted next cycle.
- Owner req3 drops valid for 5 cycles mid-packet while req0 requests, out_ready toggling 1/0 -> grant stays 1000, out_valid=0 during the gap, req_ready[0]=0, no byte of req0 interleaved.
- Assert rst during req2's second byte of 4 -> the cycle after rst: grant=0, out_valid=0. After release with req0 and req2 valid -> req0 granted first (ptr=0).
